// File: rtl/usb_pkg.sv
// Shared USB serial-path definitions: bit-stuffer state encoding and stuffing run length.
package usb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PASS  = 2'd1,
    STUFF = 2'd2
  } bs_state_t;

  localparam int USB_STUFF_LEN = 6;

endpackage

// File: rtl/bit_stuff.sv
// USB bit stuffer: inserts a 0 after every STUFF_LEN consecutive accepted 1s,
// stalling upstream for the single cycle in which the inserted 0 is emitted.
//
//   state | meaning
//   IDLE  | no packet open, bit_out parked at 1
//   PASS  | forwarding accepted bits with one cycle of latency
//   STUFF | emitting the inserted 0, upstream stalled
module bit_stuff
  import usb_pkg::*;
#(
  parameter int STUFF_LEN = USB_STUFF_LEN
) (
  input  logic clk,
  input  logic rst_b,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic stream_begin,
  input  logic stream_done,
  output logic stall,
  output logic bit_out,
  output logic out_valid,
  output logic stuffed,
  output logic busy
);

  localparam logic [2:0] STUFF_MAX = 3'(STUFF_LEN - 1);

  bs_state_t  state, state_n;
  logic [2:0] ones_cnt, ones_n;
  logic       done_pending, done_n;
  logic       bit_n, valid_n, stuffed_n;

  assign stall = (state == STUFF);
  assign busy  = (state != IDLE);

  always_comb begin
    state_n   = state;
    ones_n    = ones_cnt;
    done_n    = done_pending;
    bit_n     = bit_out;
    valid_n   = out_valid;
    stuffed_n = stuffed;
    case (state)
      IDLE: begin
        bit_n     = 1'b1;
        valid_n   = 1'b0;
        stuffed_n = 1'b0;
        done_n    = 1'b0;
        if (stream_begin) begin
          state_n = PASS;
          ones_n  = '0;
        end
      end
      PASS: begin
        if (bit_valid) begin
          bit_n     = bit_in;
          valid_n   = 1'b1;
          stuffed_n = 1'b0;
          if (bit_in && ones_cnt == STUFF_MAX) begin
            // The stuffed 0 must still go out when this is the packet's last bit.
            state_n = STUFF;
            ones_n  = '0;
            done_n  = stream_done;
          end else begin
            ones_n = bit_in ? ones_cnt + 3'd1 : 3'd0;
            if (stream_done) state_n = IDLE;
          end
        end else begin
          // Run length holds across gaps in bit_valid.
          valid_n   = 1'b0;
          stuffed_n = 1'b0;
        end
      end
      STUFF: begin
        bit_n     = 1'b0;
        valid_n   = 1'b1;
        stuffed_n = 1'b1;
        done_n    = 1'b0;
        state_n   = done_pending ? IDLE : PASS;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state        <= IDLE;
      ones_cnt     <= '0;
      done_pending <= 1'b0;
      bit_out      <= 1'b1;
      out_valid    <= 1'b0;
      stuffed      <= 1'b0;
    end else begin
      state        <= state_n;
      ones_cnt     <= ones_n;
      done_pending <= done_n;
      bit_out      <= bit_n;
      out_valid    <= valid_n;
      stuffed      <= stuffed_n;
    end
  end

endmodule

// File: tb/tb_bit_stuff.sv
// Directed bench for bit_stuff: packets with hand-computed stuffed output streams.
module tb_bit_stuff;

  logic clk = 1'b0;
  logic rst_b, bit_in, bit_valid, stream_begin, stream_done;
  logic stall, bit_out, out_valid, stuffed, busy;

  int n_vec  = 0;
  int n_miss = 0;

  logic [63:0] cap_bits, cap_stf;
  int          cap_n, stall_n;
  logic        last_busy;

  always #5 clk = ~clk;

  bit_stuff dut (
    .clk          (clk),
    .rst_b        (rst_b),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .stream_begin (stream_begin),
    .stream_done  (stream_done),
    .stall        (stall),
    .bit_out      (bit_out),
    .out_valid    (out_valid),
    .stuffed      (stuffed),
    .busy         (busy)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One clock; sample #1 after the edge and record any valid output bit.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (stall) stall_n++;
    if (out_valid && cap_n < 64) begin
      cap_bits[cap_n] = bit_out;
      cap_stf[cap_n]  = stuffed;
      cap_n++;
    end
  endtask

  task automatic clear_cap();
    cap_bits = '0;
    cap_stf  = '0;
    cap_n    = 0;
    stall_n  = 0;
  endtask

  // bits/gaps are LSB-first; a gap entry drives bit_valid=0 for one cycle.
  task automatic run_packet(input logic [31:0] bits, input logic [31:0] gaps,
                            input int n, input bit done_last);
    stream_begin = 1'b1;
    bit_valid    = 1'b1;
    bit_in       = 1'b0;
    stream_done  = 1'b1;
    cycle();
    check("begin_not_accepted", {63'd0, out_valid}, 64'd0);
    stream_begin = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps[i]) begin
        bit_valid   = 1'b0;
        stream_done = 1'b0;
        cycle();
        check("gap_out_valid", {63'd0, out_valid}, 64'd0);
      end else begin
        bit_valid   = 1'b1;
        bit_in      = bits[i];
        stream_done = done_last && (i == n - 1);
        for (int g = 0; stall; g++) begin
          if (g > 8) begin
            check("stall_timeout", 64'd1, 64'd0);
            break;
          end
          cycle();
        end
        cycle();
      end
    end
    last_busy = busy;
  endtask

  task automatic flush(input int n);
    bit_valid   = 1'b0;
    stream_done = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic check_stream(input string tag, input int exp_n,
                              input logic [63:0] exp_bits, input logic [63:0] exp_stf,
                              input int exp_stall);
    check({tag, "_len"},   64'(cap_n),   64'(exp_n));
    check({tag, "_bits"},  cap_bits,     exp_bits);
    check({tag, "_stf"},   cap_stf,      exp_stf);
    check({tag, "_stall"}, 64'(stall_n), 64'(exp_stall));
    check({tag, "_idle"},  {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst_b        = 1'b0;
    bit_in       = 1'b0;
    bit_valid    = 1'b0;
    stream_begin = 1'b0;
    stream_done  = 1'b0;
    clear_cap();
    cycle();
    cycle();
    check("rst_state", {59'd0, bit_out, out_valid, stuffed, stall, busy}, 64'b10000);
    rst_b = 1'b1;
    cycle();

    // Basic stuff: 1,1,1,1,1,1,0,1 -> 1,1,1,1,1,1,0s,0,1
    clear_cap();
    run_packet(32'b1011_1111, 32'd0, 8, 1'b1);
    check("basic_busy_last", {63'd0, last_busy}, 64'd0);
    flush(3);
    check_stream("basic", 9, 64'h13F, 64'h040, 1);

    // Twelve 1s: stuffed 0 after the 6th and 12th
    clear_cap();
    run_packet(32'hFFF, 32'd0, 12, 1'b1);
    flush(4);
    check_stream("rep", 14, 64'h1FBF, 64'h2040, 2);

    // Five-1 runs never stuff
    clear_cap();
    run_packet(32'b111_1101_1111, 32'd0, 11, 1'b1);
    check("nostuff_busy_last", {63'd0, last_busy}, 64'd0);
    flush(3);
    check_stream("nostuff", 11, 64'h7DF, 64'h000, 0);

    // Stuff on the last bit: STUFF then IDLE
    clear_cap();
    run_packet(32'h3F, 32'd0, 6, 1'b1);
    check("end_busy_last", {63'd0, last_busy}, 64'd1);
    check("end_stall", {63'd0, stall}, 64'd1);
    cycle();
    check("end_stuff_out", {61'd0, out_valid, stuffed, bit_out}, 64'b110);
    check("end_to_idle", {63'd0, busy}, 64'd0);
    cycle();
    check("end_valid_drop", {63'd0, out_valid}, 64'd0);
    flush(2);
    check_stream("end", 7, 64'h3F, 64'h40, 1);

    // Gaps: ones run spans three idle cycles
    clear_cap();
    run_packet(32'b1_1100_0111, 32'b0_0011_1000, 9, 1'b1);
    flush(4);
    check_stream("gap", 7, 64'h3F, 64'h40, 1);

    // Reset during the stuff cycle
    clear_cap();
    run_packet(32'h3F, 32'd0, 6, 1'b0);
    check("rstuff_stall", {63'd0, stall}, 64'd1);
    rst_b = 1'b0;
    cycle();
    check("rstuff_state", {60'd0, out_valid, stall, busy, bit_out}, 64'b0001);
    rst_b = 1'b1;
    clear_cap();
    run_packet(32'b01_1111, 32'd0, 6, 1'b1);
    flush(3);
    check_stream("rstuff_new", 6, 64'h1F, 64'h00, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bit_stuff.md
BIT_STUFF -- requirements
Module: bit_stuff

Interface
REQ-001 Parameter: STUFF_LEN, 6, count of consecutive 1s after which a 0 is inserted.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_b  input  1  reset, synchronous and active-low.
REQ-004 bit_in  input  1  serial data bit from the upstream CRC/serializer stage.
REQ-005 bit_valid  input  1  bit_in is valid this cycle.
REQ-006 stream_begin  input  1  one-cycle pulse that opens a packet.
REQ-007 stream_done  input  1  marks the current valid bit as the last bit of the packet.
REQ-008 stall  output  1  upstream holds bit_in, bit_valid and stream_done unchanged this cycle.
REQ-009 bit_out  output  1  stuffed serial bit to the downstream NRZI stage.
REQ-010 out_valid  output  1  bit_out is valid this cycle.
REQ-011 stuffed  output  1  bit_out is an inserted 0.
REQ-012 busy  output  1  block is not in IDLE.

Function
REQ-013 The block SHALL have three states (IDLE, PASS, STUFF) and a 3-bit ones counter ones_cnt.
REQ-014 IDLE: bit_valid and stream_done ignored; stream_begin moves to PASS at the next edge, with ones_cnt=0.
REQ-015 A bit SHALL be accepted when state==PASS, bit_valid=1 and stall=0.
REQ-016 Accepted bit: bit_out<=bit_in, out_valid<=1, stuffed<=0 at the same edge (1-cycle latency).
REQ-017 Accepted 1: ones_cnt increments. Accepted 0: ones_cnt clears.
REQ-018 An accepted 1 with ones_cnt==STUFF_LEN-1 SHALL move to STUFF and clear ones_cnt.
REQ-019 PASS with bit_valid=0: out_valid<=0 and ones_cnt holds, so a run of 1s spans gaps.
REQ-020 stall SHALL equal (state==STUFF), decoded from state without registering; it is 0 in IDLE and PASS.
REQ-021 STUFF lasts exactly one cycle.
  - Edge ending it: bit_out<=0, stuffed<=1, out_valid<=1.
  - Next state: PASS, or IDLE if done_pending.
REQ-022 stream_done SHALL be sampled only with an accepted bit.
  - Next state: IDLE, unless that bit triggers STUFF.
  - In that case set done_pending; STUFF then exits to IDLE and clears done_pending.
REQ-023 A 0 is inserted after the sixth 1 even when that 1 is the last bit of the packet.
REQ-024 Entering IDLE: out_valid<=0 and stuffed<=0 at the following edge; bit_out holds 1 while idle.
REQ-025 stream_begin outside IDLE SHALL be ignored.
  - A bit presented together with stream_begin in IDLE is not accepted.
  - The first accepted bit is the cycle after stream_begin.
REQ-026 busy SHALL be decoded from state (not IDLE) without registering.

Reset
REQ-027 When rst_b=0 at an edge, the following SHALL take effect after that edge:
  - state=IDLE, ones_cnt=0, done_pending=0;
  - bit_out=1, out_valid=0, stuffed=0;
  - stall=0, busy=0.
REQ-028 Reset mid-packet (including in STUFF) SHALL abandon the packet with no further out_valid.

Structure
REQ-029 A shared package usb_pkg SHALL hold the state enum bs_state_t {IDLE, PASS, STUFF} and the constant USB_STUFF_LEN=6, used as the parameter default.
REQ-030 No sub-module; one sequential process plus one next-state/output decode.

Verification
REQ-031 Basic stuff: begin, then bits 1,1,1,1,1,1,0,1 with done on the last bit.
  - Output: 1,1,1,1,1,1,0(stuffed),0,1.
  - stall=1 for exactly the one cycle after the sixth 1 is accepted.
  - busy drops after the final bit.
REQ-032 Repeated stuffing: twelve consecutive 1s.
  - A stuffed 0 follows the 6th and the 12th 1.
  - Output length is 14 valid bits.
REQ-033 No stuff: bits 1,1,1,1,1,0,1,1,1,1,1 with done on the last bit.
  - Output is identical to the input.
  - stuffed and stall never assert.
REQ-034 Stuff at end: six 1s with done on the sixth.
  - Output: six 1s then a stuffed 0.
  - State goes STUFF->IDLE; out_valid=0 on the next cycle.
REQ-035 Gaps: 1,1,1, three cycles of bit_valid=0, then 1,1,1.
  - A stuffed 0 follows the sixth 1.
  - out_valid=0 during the gap cycles.
REQ-036 Reset in STUFF: rst_b=0 during the stall cycle.
  - Next cycle: out_valid=0, stall=0, busy=0, bit_out=1.
  - A new stream_begin then starts with ones_cnt=0.
